// File: rtl/wimax_pkg.sv
// Shared types for the WiMAX transmit datapath.
// Reset-sequencer states and datapath reset-domain indices.
package wimax_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int STG_FEC   = 0;
   localparam int STG_INTLV = 1;
   localparam int STG_MAP   = 2;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level.
// Clears to 0 on rst_n so nothing is seen as asserted out of reset.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   // shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds datapath domains in reset until the PLL is stably locked,
// then releases them one by one, re-sequencing on lock loss or soft reset.
module pll_reset_sequencer
   import wimax_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int STAGE_GAP     = 16,
   parameter int N_STAGES      = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                locked,
   input  logic                soft_rst,
   output logic [N_STAGES-1:0] stage_rst_n,
   output logic                ready,
   output logic                lock_lost,
   output logic [7:0]          relock_cnt
);

   localparam int SW = $clog2(STABLE_CYCLES);
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
   localparam logic [N_STAGES-1:0] ALL_ON = '1;
   localparam logic [N_STAGES-1:0] FIRST  = N_STAGES'(1);

   logic lk;
   logic sr;

   seq_state_t state_q, state_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [N_STAGES-1:0] stg_q, stg_d;
   logic ready_q, ready_d;
   logic lost_q, lost_d;
   logic [7:0] rcnt_q, rcnt_d;

   sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (lk)
   );

   sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sr (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (soft_rst),
      .q     (sr)
   );

   // state, counters and registered reset outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_LOCK;
         stab_q  <= '0;
         gap_q   <= '0;
         stg_q   <= '0;
         ready_q <= 1'b0;
         lost_q  <= 1'b0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         gap_q   <= gap_d;
         stg_q   <= stg_d;
         ready_q <= ready_d;
         lost_q  <= lost_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // next state; stage mask fills with ones from stage 0 upward
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      gap_d   = gap_q;
      stg_d   = stg_q;
      ready_d = ready_q;
      lost_d  = lost_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         WAIT_LOCK: begin
            stg_d   = '0;
            ready_d = 1'b0;
            stab_d  = '0;
            gap_d   = '0;
            if (lk && !sr) state_d = STABLE;
         end
         STABLE: begin
            if (!lk || sr) begin
               state_d = WAIT_LOCK;
               stab_d  = '0;
            end else if (stab_q == STAB_LAST) begin
               state_d = RELEASE;
               stab_d  = '0;
               gap_d   = '0;
               stg_d   = FIRST;
               if (stg_d == ALL_ON) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end else begin
               stab_d = stab_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!lk || sr) begin
               state_d = WAIT_LOCK;
               stg_d   = '0;
               gap_d   = '0;
            end else if (gap_q == GAP_LAST) begin
               gap_d = '0;
               stg_d = (stg_q << 1) | FIRST;
               if (stg_d == ALL_ON) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         RUN: begin
            if (!lk) begin
               lost_d  = 1'b1;
               rcnt_d  = sat_inc8(rcnt_q);
               stg_d   = '0;
               ready_d = 1'b0;
               state_d = WAIT_LOCK;
            end else if (sr) begin
               stg_d   = '0;
               ready_d = 1'b0;
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            stg_d   = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   assign stage_rst_n = stg_q;
   assign ready       = ready_q;
   assign lock_lost   = lost_q;
   assign relock_cnt  = rcnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pll_reset_sequencer;
   import wimax_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic       soft_rst;
   logic [2:0] stage_rst_n;
   logic       ready;
   logic       lock_lost;
   logic [7:0] relock_cnt;

   int n_vec = 0;
   int n_bad = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (16),
      .STAGE_GAP     (4),
      .N_STAGES      (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .locked      (locked),
      .soft_rst    (soft_rst),
      .stage_rst_n (stage_rst_n),
      .ready       (ready),
      .lock_lost   (lock_lost),
      .relock_cnt  (relock_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // locked rises now; stage 0 at +19, stage 1 at +23, stage 2 at +27
   task automatic expect_seq(input string tag);
      locked = 1'b1;
      tick(18);
      chk({tag, "_t18"}, stage_rst_n, 3'b000);
      tick(1);
      chk({tag, "_t19"}, stage_rst_n, 3'b001);
      chk({tag, "_fec"}, stage_rst_n[STG_FEC], 1'b1);
      tick(3);
      chk({tag, "_t22"}, stage_rst_n, 3'b001);
      tick(1);
      chk({tag, "_t23"}, stage_rst_n, 3'b011);
      tick(3);
      chk({tag, "_t26"}, stage_rst_n, 3'b011);
      chk({tag, "_rdy26"}, ready, 1'b0);
      tick(1);
      chk({tag, "_t27"}, stage_rst_n, 3'b111);
      chk({tag, "_map"}, stage_rst_n[STG_MAP], 1'b1);
      chk({tag, "_rdy27"}, ready, 1'b1);
   endtask

   initial begin
      rst_n    = 1'b0;
      locked   = 1'b0;
      soft_rst = 1'b0;
      tick(2);
      chk("rst_stg", stage_rst_n, 3'b000);
      chk("rst_rdy", ready, 1'b0);
      chk("rst_lost", lock_lost, 1'b0);
      chk("rst_cnt", relock_cnt, 8'd0);

      rst_n = 1'b1;
      expect_seq("pwr");
      chk("pwr_lost", lock_lost, 1'b0);

      soft_rst = 1'b1;
      tick(2);
      chk("soft_hold", stage_rst_n, 3'b111);
      tick(1);
      chk("soft_stg", stage_rst_n, 3'b000);
      chk("soft_rdy", ready, 1'b0);
      tick(1);
      soft_rst = 1'b0;
      expect_seq("soft");
      chk("soft_lost", lock_lost, 1'b0);
      chk("soft_cnt", relock_cnt, 8'd0);

      locked = 1'b0;
      tick(2);
      chk("loss_hold", stage_rst_n, 3'b111);
      tick(1);
      chk("loss_stg", stage_rst_n, 3'b000);
      chk("loss_rdy", ready, 1'b0);
      chk("loss_lost", lock_lost, 1'b1);
      chk("loss_cnt", relock_cnt, 8'd1);
      expect_seq("relock");

      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(11);
      locked = 1'b0;
      tick(3);
      chk("glitch_stg", stage_rst_n, 3'b000);
      chk("glitch_cnt", relock_cnt, 8'd2);
      expect_seq("restart");
      chk("restart_cnt", relock_cnt, 8'd2);

      for (int i = 0; i < 260; i++) begin
         locked = 1'b0;
         tick(3);
         locked = 1'b1;
         tick(27);
      end
      chk("sat_rdy", ready, 1'b1);
      chk("sat_cnt", relock_cnt, 8'd255);

      locked = 1'b0;
      tick(3);
      chk("sat_hold", relock_cnt, 8'd255);
      locked = 1'b1;
      tick(23);
      chk("mid_stg", stage_rst_n, 3'b011);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_stg", stage_rst_n, 3'b000);
      chk("async_rdy", ready, 1'b0);
      chk("async_lost", lock_lost, 1'b0);
      chk("async_cnt", relock_cnt, 8'd0);
      tick(2);
      rst_n = 1'b1;
      expect_seq("post");

      locked   = 1'b0;
      soft_rst = 1'b1;
      tick(3);
      chk("both_stg", stage_rst_n, 3'b000);
      chk("both_lost", lock_lost, 1'b1);
      chk("both_cnt", relock_cnt, 8'd1);
      soft_rst = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
